// File: rtl/jtag_bitbang_host.sv
// jtag_bitbang_host: remote-bitbang command byte interpreter driving JTAG-DTM pins.
// Accepts one command byte per handshake. It updates the tck/tms/tdi and
// trst_n/srst_n pins, answers 'R' read requests, and drives the led and quit flags.
// Build option: define JTAG_BITBANG_TDO_SYNC_EN to pass tdo through a two-flop
// synchroniser. Without it, tdo passes through a single register.
//
//   state | meaning
//   IDLE  | ready for the next command byte (unless quit is set)
//   HOLD  | pins just changed; keep them stable for HOLD_CYCLES cycles
//   RESP  | read response presented, waiting for rsp_ready
module jtag_bitbang_host #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       tck,
    output logic       tms,
    output logic       tdi,
    output logic       trst_n,
    output logic       srst_n,
    input  logic       tdo,
    output logic       led,
    output logic       quit,
    output logic       cmd_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RESP} state_e;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic        trst_n_q, trst_n_d, srst_n_q, srst_n_d;
    logic        led_q, led_d, quit_q, quit_d, cmd_err_q, cmd_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        tdo_sync;

    logic        accept;
    logic        is_pin, is_rst, is_read;
    logic [1:0]  rst_sel;

    assign accept  = cmd_valid && (state_q == ST_IDLE) && !quit_q;
    assign is_pin  = (cmd_data[7:3] == 5'b00110);
    assign is_rst  = (cmd_data >= 8'h72) && (cmd_data <= 8'h75);
    assign is_read = (cmd_data == 8'h52);
    // Offset from 'r': 'r'=0 (none), 's'=1 (srst), 't'=2 (trst), 'u'=3 (both)
    assign rst_sel = cmd_data[1:0] - 2'b10;

`ifdef JTAG_BITBANG_TDO_SYNC_EN
    logic tdo_s1_q, tdo_s2_q;

    // Two-flop synchroniser for tdo coming from the tck domain
    always_ff @(posedge clk) begin
        if (rst) begin
            tdo_s1_q <= 1'b0;
            tdo_s2_q <= 1'b0;
        end else begin
            tdo_s1_q <= tdo;
            tdo_s2_q <= tdo_s1_q;
        end
    end
    assign tdo_sync = tdo_s2_q;
`else
    logic tdo_s1_q;

    // Single capture register for tdo
    always_ff @(posedge clk) begin
        if (rst) tdo_s1_q <= 1'b0;
        else     tdo_s1_q <= tdo;
    end
    assign tdo_sync = tdo_s1_q;
`endif

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= 8'd0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_n_q    <= 1'b1;
            srst_n_q    <= 1'b1;
            led_q       <= 1'b0;
            quit_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_n_q    <= trst_n_d;
            srst_n_q    <= srst_n_d;
            led_q       <= led_d;
            quit_q      <= quit_d;
            cmd_err_q   <= cmd_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic with the hold down-counter (terminal count at 1, never wraps)
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_pin || is_rst) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_INIT;
                    end else if (is_read) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q <= 8'd1) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: cmd_ready plus next values of the registered outputs
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE) && !quit_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_n_d    = trst_n_q;
        srst_n_d    = srst_n_q;
        led_d       = led_q;
        quit_d      = quit_q;
        cmd_err_d   = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            if (is_pin) begin
                tck_d = cmd_data[2];
                tms_d = cmd_data[1];
                tdi_d = cmd_data[0];
            end else if (is_rst) begin
                trst_n_d = ~rst_sel[1];
                srst_n_d = ~rst_sel[0];
            end else begin
                case (cmd_data)
                    8'h52: begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = tdo_sync ? 8'h31 : 8'h30;
                    end
                    8'h42:   led_d     = 1'b1;
                    8'h62:   led_d     = 1'b0;
                    8'h51:   quit_d    = 1'b1;
                    default: cmd_err_d = 1'b1;
                endcase
            end
        end
        if ((state_q == ST_RESP) && rsp_ready) rsp_valid_d = 1'b0;
    end

    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst_n    = trst_n_q;
    assign srst_n    = srst_n_q;
    assign led       = led_q;
    assign quit      = quit_q;
    assign cmd_err   = cmd_err_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/jtag_bitbang_host.md
JTAG_BITBANG_HOST -- requirements
Module: jtag_bitbang_host

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the number of clk cycles pins are held after a pin-changing command (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_data (input, 8), carrying remote-bitbang command bytes; transfer occurs when cmd_valid && cmd_ready.
REQ-005 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_data (output, 8), carrying the read response byte.
REQ-006 SHALL have ports tck, tms, tdi, trst_n and srst_n, each an output of width 1, which drive the JTAG-DTM pins and the system reset request.
REQ-007 SHALL have port tdo, input, 1, driven by the JTAG-DTM from the tck domain and treated as asynchronous.
REQ-008 SHALL have ports led (output, 1), quit (output, 1, sticky) and cmd_err (output, 1, single-cycle pulse).

Function
REQ-009 SHALL implement three states: IDLE, HOLD and RESP. cmd_ready is 1 only in IDLE with quit=0.
REQ-010 SHALL decode '0'..'7' (0x30..0x37) as pin writes: tck=bit2, tms=bit1, tdi=bit0. The pins update on the cycle after acceptance, and the state goes to HOLD.
REQ-011 SHALL decode 'r','s','t','u' (0x72..0x75) as reset writes: bit1 means trst asserted (trst_n=0) and bit0 means srst asserted (srst_n=0). The pins update on the cycle after acceptance, and the state goes to HOLD.
REQ-012 SHALL keep cmd_ready low in HOLD for exactly HOLD_CYCLES cycles, counted from the cycle after acceptance, then return to IDLE. The counter is 8 bits and does not wrap.
REQ-013 SHALL decode 'R' (0x52) by capturing the synchronised tdo in the acceptance cycle. On the next cycle it SHALL assert rsp_valid with rsp_data = 0x31 if tdo=1, else 0x30, and enter RESP.
REQ-014 SHALL hold rsp_valid and rsp_data stable in RESP until rsp_ready=1. The state returns to IDLE in that same cycle, so cmd_ready=1 on the following cycle.
REQ-015 SHALL decode 'B' as led=1 and 'b' as led=0. Each takes effect on the next cycle, with no hold and the state staying in IDLE.
REQ-016 SHALL decode 'Q' by setting quit=1 on the next cycle. quit SHALL then stay set until rst, which holds cmd_ready at 0.
REQ-017 SHALL handle any other byte by pulsing cmd_err for one cycle after acceptance, with no other state change.
REQ-018 SHALL keep all unaffected pins unchanged: a pin write never alters trst_n or srst_n, and a reset write never alters tck, tms or tdi.
REQ-019 SHALL register all outputs, with no combinational path from cmd_* or rsp_ready to outputs other than cmd_ready's dependency on state.

Reset
REQ-020 SHALL reset on rst to: state IDLE; tck=0, tms=1, tdi=0, trst_n=1, srst_n=1; led=0, quit=0, cmd_err=0; rsp_valid=0, rsp_data=0x00; hold counter=0; tdo synchroniser flops=0.
REQ-021 SHALL honour rst asserted mid-HOLD or mid-RESP: the next cycle shows reset values, and any pending response is discarded.
REQ-022 SHALL make cmd_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, when macro JTAG_BITBANG_TDO_SYNC_EN is defined, pass tdo through a two-flop synchroniser before capture. 'R' then reflects tdo as it was two clk cycles before acceptance.
REQ-024 SHALL, when JTAG_BITBANG_TDO_SYNC_EN is undefined, pass tdo through a single register. 'R' then reflects tdo one clk cycle before acceptance. The interface and all other timing are identical in both builds.

Verification
REQ-025 SHALL cover pin write: send 0x36 with HOLD_CYCLES=4 -> next cycle tck=1, tms=1, tdi=0; cmd_ready=0 for exactly 4 cycles, then 1.
REQ-026 SHALL cover read: tdo=1 held stable for 4 cycles, send 'R' with rsp_ready=0 for 3 cycles -> rsp_valid=1 and rsp_data=0x31 held stable; IDLE follows the rsp_ready handshake.
REQ-027 SHALL cover reset commands: send 'u' then 'r' -> trst_n=0 and srst_n=0, then both return to 1; tck, tms and tdi stay unchanged throughout.
REQ-028 SHALL cover misc commands: send 'B', 'x', 'Q', '1' -> led=1, cmd_err pulses once after 'x', quit=1, cmd_ready stays 0, and the '1' is never accepted.
REQ-029 SHALL cover reset mid-operation: assert rst during HOLD after 0x37 and during RESP -> outputs show REQ-020 values next cycle, rsp_valid=0, cmd_ready=1 after release.
REQ-030 SHALL cover the synchroniser build difference: toggle tdo 0->1 exactly 1 cycle before 'R' -> rsp_data=0x30 with JTAG_BITBANG_TDO_SYNC_EN and 0x31 without it.
